// File: rtl/regfile_bypass_sb_if.sv
// Operand-source bus between decode/writeback and the register file.
// master = pipeline control side, slave = register file.
interface regfile_bypass_sb_if #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int SEL_W    = 3
);
    logic [SEL_W-1:0]    read1RegSel;
    logic [SEL_W-1:0]    read2RegSel;
    logic                read1Use;
    logic                read2Use;
    logic [DATA_W-1:0]   read1Data;
    logic [DATA_W-1:0]   read2Data;
    logic                writeEn;
    logic [SEL_W-1:0]    writeRegSel;
    logic [DATA_W-1:0]   writeData;
    logic                issueEn;
    logic [SEL_W-1:0]    issueRegSel;
    logic                stall;
    logic [NUM_REGS-1:0] busyVec;
    logic                err;

    modport master (
        output read1RegSel, read2RegSel, read1Use, read2Use,
        output writeEn, writeRegSel, writeData, issueEn, issueRegSel,
        input  read1Data, read2Data, stall, busyVec, err
    );

    modport slave (
        input  read1RegSel, read2RegSel, read1Use, read2Use,
        input  writeEn, writeRegSel, writeData, issueEn, issueRegSel,
        output read1Data, read2Data, stall, busyVec, err
    );
endinterface

// File: rtl/regfile_bypass_sb.sv
// 8x16 architectural register file with two combinational read ports,
// optional write-to-read bypass and a per-register busy scoreboard.
module regfile_bypass_sb #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int SEL_W    = 3,
    parameter int BYPASS   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    regfile_bypass_sb_if.slave  rf
);

    localparam bit BYP_EN = (BYPASS != 0);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;
    logic                err_q;
    logic                byp1;
    logic                byp2;
    logic                haz1;
    logic                haz2;
    logic                waw_err;
    logic                unexp_wr_err;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (rf.issueEn) set_vec[rf.issueRegSel] = 1'b1;
        if (rf.writeEn) clr_vec[rf.writeRegSel] = 1'b1;
    end

    // Bypass only counts when the writeback targets the same register being read.
    assign byp1 = BYP_EN && rf.writeEn && (rf.writeRegSel == rf.read1RegSel);
    assign byp2 = BYP_EN && rf.writeEn && (rf.writeRegSel == rf.read2RegSel);

    assign rf.read1Data = byp1 ? rf.writeData : regs[rf.read1RegSel];
    assign rf.read2Data = byp2 ? rf.writeData : regs[rf.read2RegSel];

    assign haz1     = rf.read1Use && busy[rf.read1RegSel] && !byp1;
    assign haz2     = rf.read2Use && busy[rf.read2RegSel] && !byp2;
    assign rf.stall = haz1 | haz2;

    assign waw_err      = rf.issueEn && busy[rf.issueRegSel] &&
                          !(rf.writeEn && (rf.writeRegSel == rf.issueRegSel));
    assign unexp_wr_err = rf.writeEn && !busy[rf.writeRegSel];

    assign rf.busyVec = busy;
    assign rf.err     = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (rf.writeEn) begin
            regs[rf.writeRegSel] <= rf.writeData;
        end
    end

    // A new issue to a register being written back this cycle keeps it busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= '0;
            err_q <= 1'b0;
        end else begin
            busy  <= (busy & ~clr_vec) | set_vec;
            err_q <= err_q | waw_err | unexp_wr_err;
        end
    end

endmodule

// File: doc/regfile_bypass_sb.md
Name: regfile_bypass_sb

Overview:
- Upstream operand source for the execute-stage ALU.
- Holds the 8 x 16-bit architectural registers and provides two combinational read ports that drive ALU InA/InB.
- Has one synchronous write port from writeback, with optional write-to-read bypass.
- Keeps a per-register busy scoreboard. Decode raises a stall when a source operand has an in-flight producer.

Parameters:
- DATA_W, 16, register and data width (matches ALU operand width)
- NUM_REGS, 8, number of architectural registers
- SEL_W, 3, register select width (log2 NUM_REGS)
- BYPASS, 1, 1 = same-cycle writeData forwarded to reads; 0 = reads see only stored value

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- read1RegSel  in  SEL_W  source register A select
- read2RegSel  in  SEL_W  source register B select
- read1Use  in  1  source A is consumed by the instruction in decode
- read2Use  in  1  source B is consumed by the instruction in decode
- read1Data  out  DATA_W  operand A (to ALU InA)
- read2Data  out  DATA_W  operand B (to ALU InB)
- writeEn  in  1  writeback write strobe
- writeRegSel  in  SEL_W  writeback destination
- writeData  in  DATA_W  writeback value
- issueEn  in  1  decode issues an instruction that writes a register
- issueRegSel  in  SEL_W  destination of the issued instruction
- stall  out  1  decode must hold; a used source is busy and not being bypassed
- busyVec  out  NUM_REGS  current scoreboard bits (debug/verification)
- err  out  1  sticky error flag

Behaviour:
- Reset (rst_n low, asynchronous):
  - all registers = 0, busyVec = 0, err = 0
  - read outputs then reflect 0 (or bypassed writeData if BYPASS=1 and writeEn is high)
  - reset mid-operation discards all pending busy bits immediately, without waiting for a clock edge
- Write: on posedge with writeEn=1, reg[writeRegSel] <= writeData. No write when writeEn=0.
- Read: combinational.
  - readNData = reg[readNRegSel]
  - if BYPASS=1 and writeEn=1 and writeRegSel==readNRegSel, then readNData = writeData (same cycle)
  - read1 and read2 may select the same register; both get the identical value
- Scoreboard, per register i, evaluated on posedge:
  - set = issueEn && issueRegSel==i
  - clr = writeEn && writeRegSel==i
  - set && clr: busy[i] <= 1 (the newer producer wins)
  - set only: busy[i] <= 1
  - clr only: busy[i] <= 0
  - neither: hold
- stall (combinational) = hazA | hazB
  - hazN = readNUse && busy[readNRegSel] && !(BYPASS && writeEn && writeRegSel==readNRegSel)
  - readNUse=0 never stalls, regardless of busy
- Issue-while-stalled: the block does not gate issueEn with stall. Decode must hold issueEn low while stall=1.
- err, sticky until reset, set on posedge when either holds:
  - issueEn to a register already busy with no same-cycle clear (WAW with producer in flight)
  - writeEn to a register whose busy bit is 0 (unexpected writeback)
  - the offending write still updates the register
- Latency:
  - write visible through stored path one cycle after the edge; through bypass in the same cycle
  - busy set visible in stall the cycle after issue
- Register 0 is an ordinary register (no hardwired zero).

Test Plan:
- Reset then read: rst_n=0 with writeEn=0 -> read1Data=read2Data=0x0000, busyVec=0, err=0, stall=0.
- Write then read: writeEn, sel=3, data=0xBEEF at edge; next cycle read1RegSel=3 -> 0xBEEF.
- Bypass: writeEn, sel=5, data=0x1234, read2RegSel=5 in the same cycle -> read2Data=0x1234 before the edge (BYPASS=1). BYPASS=0 -> read2Data shows the old value.
- Scoreboard stall/release:
  - issueEn sel=2, then read1Use=1, read1RegSel=2 -> stall=1
  - writeEn sel=2 data=0x00FF -> stall=0 in that cycle, read1Data=0x00FF
  - next cycle busyVec[2]=0
- Simultaneous set/clear: issueEn sel=4 and writeEn sel=4 on the same edge (busy[4]=1 beforehand) -> busy[4] stays 1, err stays 0.
- Error and async reset:
  - writeEn sel=6 with busy[6]=0 -> err=1 after the edge
  - err stays 1 across further cycles
  - mid-cycle rst_n low -> err=0 and busyVec=0 immediately, without a clock edge
